// File: rtl/fifo_pkg.sv
// Shared FIFO constants, port-direction encodings and controller state type.
// Used by the controller, its pointer registers and the memory/tester pair.
package fifo_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 4;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fifoState_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit queue pointer: ADDR_W address bits plus one MSB that toggles per lap.
// Latency: new value one cycle after inc.
// Backpressure: none; the caller gates inc with its own full/empty decision.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              inc,
    output logic [ADDR_W:0]   ptr
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Push/pop queue controller over a dual-port RAM (port A writes, port B reads).
// Latency: popped word appears on data_out one cycle after an accepted pop.
// Backpressure: push dropped when full, pop dropped when empty, both sticky-flagged.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              ready,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W-1:0] AddrA,
    output logic [ADDR_W-1:0] AddrB,
    output logic              rwA,
    output logic              rwB,
    output logic [DATA_W-1:0] DataInA,
    output logic [DATA_W-1:0] DataInB,
    input  logic [DATA_W-1:0] DataOutB
);

    localparam logic [ADDR_W:0]   ONE       = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   AF_LVL    = (ADDR_W + 1)'(AF_THR);
    localparam logic [ADDR_W:0]   AE_LVL    = (ADDR_W + 1)'(AE_THR);
    localparam logic [ADDR_W-1:0] INIT_LAST = '1;

    fifoState_t        state, stateNext;
    logic [ADDR_W-1:0] initCnt;
    logic [ADDR_W:0]   wrPtr, rdPtr, countNext;
    logic              pushAcc, popAcc;

    fifo_ptr #(.ADDR_W(ADDR_W)) uWrPtr (.clk(clk), .reset_L(reset_L), .inc(pushAcc), .ptr(wrPtr));
    fifo_ptr #(.ADDR_W(ADDR_W)) uRdPtr (.clk(clk), .reset_L(reset_L), .inc(popAcc),  .ptr(rdPtr));

    // Wrap-bit pointer difference is the occupancy, 0..DEPTH, with no extra counter.
    assign count = wrPtr - rdPtr;

    always_comb begin
        stateNext = state;
        AddrA     = wrPtr[ADDR_W-1:0];
        rwA       = RW_READ;
        DataInA   = '0;
        ready     = 1'b0;
        pushAcc   = 1'b0;
        popAcc    = 1'b0;
        case (state)
            INIT: begin
                AddrA = initCnt;
                rwA   = RW_WRITE;
                if (initCnt == INIT_LAST) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                ready   = 1'b1;
                pushAcc = push && !full;
                popAcc  = pop && !empty;
                if (pushAcc) begin
                    rwA     = RW_WRITE;
                    DataInA = data_in;
                end
            end
            default: stateNext = INIT;
        endcase
    end

    always_comb begin
        countNext = count;
        case ({pushAcc, popAcc})
            2'b10:   countNext = count + ONE;
            2'b01:   countNext = count - ONE;
            default: countNext = count;
        endcase
    end

    assign AddrB    = rdPtr[ADDR_W-1:0];
    assign rwB      = RW_READ;
    assign DataInB  = '0;
    assign data_out = valid_out ? DataOutB : '0;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state        <= INIT;
            initCnt      <= '0;
            valid_out    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state        <= stateNext;
            valid_out    <= popAcc;
            full         <= (countNext == DEPTH_LVL);
            empty        <= (countNext == '0);
            almost_full  <= (countNext >= AF_LVL);
            almost_empty <= (countNext <= AE_LVL);
            if (state == INIT) begin
                initCnt <= initCnt + 1'b1;
            end
            if (state == RUN && push && full) begin
                overflow <= 1'b1;
            end
            if (state == RUN && pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
